// File: rtl/slave_mem_burst_pkg.sv
// Shared types and constants for the burst-capable serial memory slave.
package slave_mem_burst_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_A,
        ST_NAK,
        ST_WRITE,
        ST_ACK_W,
        ST_READ
    } state_t;

    localparam int ACK_CYCLES = 2;
    localparam int NAK_CYCLES = 2;

endpackage

// File: rtl/slave_mem_burst_counter.sv
// Generic up-counter with synchronous reset and a clear that outranks enable.
module slave_mem_burst_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Count up while enabled; clear restarts from zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/slave_mem_burst.sv
// Serial bus slave with on-chip memory and auto-incrementing, wrapping bursts.
// Frame: address bits LSB-first, then burst field (beats = field + 1).
// Handshake: the master holds AD_SEL high for the whole frame; dropping it in any
// busy state aborts to IDLE on the next edge. Every output is a register.
module slave_mem_burst
    import slave_mem_burst_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                MEM_DEPTH = 4096,
    parameter int                ADDR_W    = $clog2(MEM_DEPTH),
    parameter int                BURST_W   = 2,
    parameter logic [DATA_W-1:0] INIT_VAL  = DATA_W'(8'hAD)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              AD_SEL,
    input  logic              B_RW,
    input  logic              B_BUS_OUT,
    output logic              B_BUS_IN,
    output logic              B_ACK,
    output logic              B_SBSY,
    output logic              B_READY,
    output logic              S_DVALID,
    output logic [DATA_W-1:0] S_DOUT,
    output logic [ADDR_W-1:0] S_DADDR
);

    localparam int FRAME_W = ADDR_W + BURST_W;
    localparam int LEN_A   = (FRAME_W > DATA_W) ? FRAME_W : DATA_W;
    localparam int LEN_B   = (ACK_CYCLES > NAK_CYCLES) ? ACK_CYCLES : NAK_CYCLES;
    localparam int MAX_LEN = (LEN_A > LEN_B) ? LEN_A : LEN_B;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);
    localparam int IDX_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MEM_DEPTH - 1);

    logic [DATA_W-1:0] mem [MEM_DEPTH] = '{default: INIT_VAL};

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   bit_cnt, last_cnt;
    logic [BURST_W-1:0] beat_cnt, burst_len;
    logic [FRAME_W-1:0] frame_sr, frame_nxt;
    logic [ADDR_W-1:0]  addr, addr_inc;
    logic [DATA_W-1:0]  wdata, rd_word, rd_next;
    logic               phase_end, beats_left, abort, in_range;
    logic               bit_clr, beat_clr, beat_en, mem_we;

    // Cycle-within-phase counter; restarts at every phase (and read beat) boundary.
    slave_mem_burst_counter #(.WIDTH(CNT_W)) u_bit_cnt (
        .clk   (CLK),
        .rst   (RST),
        .clr   (bit_clr),
        .en    (1'b1),
        .count (bit_cnt)
    );

    // Completed-beat counter for the current burst.
    slave_mem_burst_counter #(.WIDTH(BURST_W)) u_beat_cnt (
        .clk   (CLK),
        .rst   (RST),
        .clr   (beat_clr),
        .en    (beat_en),
        .count (beat_cnt)
    );

    assign addr_inc = (addr == ADDR_LAST) ? '0 : addr + 1'b1;
    assign rd_word  = mem[addr];
    assign rd_next  = mem[addr_inc];

    // Phase length, next-state decision and counter/memory controls.
    always_comb begin
        last_cnt = '0;
        case (state)
            ST_ADDR:            last_cnt = CNT_W'(FRAME_W - 1);
            ST_ACK_A, ST_ACK_W: last_cnt = CNT_W'(ACK_CYCLES - 1);
            ST_NAK:             last_cnt = CNT_W'(NAK_CYCLES - 1);
            ST_WRITE, ST_READ:  last_cnt = CNT_W'(DATA_W - 1);
            default:            last_cnt = '0;
        endcase
        frame_nxt  = {B_BUS_OUT, frame_sr[FRAME_W-1:1]};
        in_range   = ({1'b0, frame_nxt[ADDR_W-1:0]} < DEPTH_LIM);
        phase_end  = (bit_cnt == last_cnt);
        beats_left = (beat_cnt != burst_len);
        abort      = (state != ST_IDLE) && !AD_SEL;

        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (AD_SEL) state_nxt = ST_ADDR;
                ST_ADDR:  if (phase_end) state_nxt = in_range ? ST_ACK_A : ST_NAK;
                ST_ACK_A: if (phase_end) state_nxt = B_RW ? ST_WRITE : ST_READ;
                ST_NAK:   if (phase_end) state_nxt = ST_IDLE;
                ST_WRITE: if (phase_end) state_nxt = ST_ACK_W;
                ST_ACK_W: if (phase_end) state_nxt = beats_left ? ST_WRITE : ST_IDLE;
                ST_READ:  if (phase_end && !beats_left) state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end

        bit_clr  = (state == ST_IDLE) || phase_end || abort;
        beat_clr = (state == ST_IDLE) || (state == ST_ADDR) ||
                   (state == ST_ACK_A) || (state == ST_NAK);
        beat_en  = phase_end && ((state == ST_ACK_W) || (state == ST_READ));
        // Commit on the first ACK_W cycle only; an abort or reset discards the word.
        mem_we   = (state == ST_ACK_W) && (bit_cnt == '0) && !abort && !RST;
    end

    // Main FSM: state, frame capture, write shifter and all registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            frame_sr  <= '0;
            addr      <= '0;
            burst_len <= '0;
            wdata     <= '0;
            B_BUS_IN  <= 1'b0;
            B_ACK     <= 1'b0;
            B_SBSY    <= 1'b0;
            B_READY   <= 1'b0;
            S_DVALID  <= 1'b0;
            S_DOUT    <= '0;
            S_DADDR   <= '0;
        end else begin
            state    <= state_nxt;
            B_ACK    <= (state_nxt == ST_ACK_A) || (state_nxt == ST_ACK_W);
            B_SBSY   <= (state_nxt != ST_IDLE);
            B_READY  <= (state_nxt == ST_IDLE);
            S_DVALID <= mem_we;
            if (mem_we) begin
                S_DOUT  <= wdata;
                S_DADDR <= addr;
            end
            if (state == ST_ADDR) begin
                frame_sr <= frame_nxt;
                if (phase_end) begin
                    addr      <= frame_nxt[ADDR_W-1:0];
                    burst_len <= frame_nxt[FRAME_W-1:ADDR_W];
                end
            end
            if (state == ST_WRITE) begin
                wdata <= {B_BUS_OUT, wdata[DATA_W-1:1]};
            end
            if (((state == ST_ACK_W) || (state == ST_READ)) && phase_end && beats_left && !abort) begin
                addr <= addr_inc;
            end
            // Read bit for the upcoming cycle; next beat's bit 0 follows with no gap.
            B_BUS_IN <= 1'b0;
            if (state_nxt == ST_READ) begin
                if (state != ST_READ) begin
                    B_BUS_IN <= rd_word[0];
                end else if (phase_end) begin
                    B_BUS_IN <= rd_next[0];
                end else begin
                    B_BUS_IN <= rd_word[IDX_W'(bit_cnt + 1'b1)];
                end
            end
        end
    end

    // Memory write port; no reset so the array maps onto RAM.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: tb/tb_slave_mem_burst.sv
// Bench for slave_mem_burst: a 4096-deep and a 3000-deep instance, driven
// on the falling edge and checked against a byte-array memory model.
module tb_slave_mem_burst;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       ad_sel [2];
    logic       b_rw [2];
    logic       b_bus_out [2];
    logic       b_bus_in [2];
    logic       b_ack [2];
    logic       b_sbsy [2];
    logic       b_ready [2];
    logic       s_dvalid [2];
    logic [7:0] s_dout [2];
    logic [11:0] s_daddr [2];

    int         depth [2] = '{4096, 3000};
    logic [7:0] mem_m [2][4096];
    logic [19:0] exp_q [$];
    logic [7:0] wd [4];
    int         pulse_cnt [2] = '{0, 0};
    int         total = 0;
    int         bad = 0;

    slave_mem_burst #(.MEM_DEPTH(4096)) dut0 (
        .CLK(clk), .RST(rst), .AD_SEL(ad_sel[0]), .B_RW(b_rw[0]), .B_BUS_OUT(b_bus_out[0]),
        .B_BUS_IN(b_bus_in[0]), .B_ACK(b_ack[0]), .B_SBSY(b_sbsy[0]), .B_READY(b_ready[0]),
        .S_DVALID(s_dvalid[0]), .S_DOUT(s_dout[0]), .S_DADDR(s_daddr[0])
    );

    slave_mem_burst #(.MEM_DEPTH(3000)) dut1 (
        .CLK(clk), .RST(rst), .AD_SEL(ad_sel[1]), .B_RW(b_rw[1]), .B_BUS_OUT(b_bus_out[1]),
        .B_BUS_IN(b_bus_in[1]), .B_ACK(b_ack[1]), .B_SBSY(b_sbsy[1]), .B_READY(b_ready[1]),
        .S_DVALID(s_dvalid[1]), .S_DOUT(s_dout[1]), .S_DADDR(s_daddr[1])
    );

    // Count write-sink pulses on each instance.
    always @(negedge clk) begin
        if (s_dvalid[0] === 1'b1) pulse_cnt[0]++;
        if (s_dvalid[1] === 1'b1) pulse_cnt[1]++;
    end

    // One full transaction. cut_bits >= 0 stops beat 0 after that many bits:
    // by dropping AD_SEL (cut_rst=0, writes) or by asserting reset (cut_rst=1, reads).
    task automatic xfer(input int s, input bit rw, input int addr, input int beats,
                        input int cut_bits, input bit cut_rst);
        logic [13:0] frame;
        logic [7:0]  got;
        logic [19:0] e;
        int          a;
        bit          nak;
        nak   = (addr >= depth[s]);
        frame = {2'(beats - 1), 12'(addr)};
        a     = addr;
        @(negedge clk);
        total++;
        if (b_ready[s] !== 1'b1 || b_sbsy[s] !== 1'b0) begin
            bad++;
            $display("FAIL idle_before s=%0d ready=%b sbsy=%b want 1/0", s, b_ready[s], b_sbsy[s]);
        end
        ad_sel[s] = 1'b1;
        b_rw[s]   = rw;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            total++;
            if ({b_sbsy[s], b_ready[s], b_ack[s]} !== 3'b100) begin
                bad++;
                $display("FAIL addr_phase s=%0d bit=%0d sbsy/ready/ack=%b%b%b want 100",
                         s, k, b_sbsy[s], b_ready[s], b_ack[s]);
            end
            b_bus_out[s] = frame[k];
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if (b_ack[s] !== !nak || b_sbsy[s] !== 1'b1) begin
                bad++;
                $display("FAIL ack_phase s=%0d cyc=%0d ack=%b sbsy=%b want %b/1",
                         s, k, b_ack[s], b_sbsy[s], !nak);
            end
        end
        if (!nak && rw) begin
            for (int j = 0; j < beats; j++) begin
                for (int k = 0; k < 8; k++) begin
                    @(negedge clk);
                    if (j == 0 && k == cut_bits) begin
                        ad_sel[s] = 1'b0;
                        @(negedge clk);
                        total++;
                        if (b_ready[s] !== 1'b1 || b_ack[s] !== 1'b0) begin
                            bad++;
                            $display("FAIL abort_idle s=%0d ready=%b ack=%b want 1/0", s, b_ready[s], b_ack[s]);
                        end
                        repeat (3) @(negedge clk);
                        return;
                    end
                    b_bus_out[s] = wd[j][k];
                end
                @(negedge clk);
                total++;
                if (b_ack[s] !== 1'b1 || s_dvalid[s] !== 1'b0) begin
                    bad++;
                    $display("FAIL ackw_first s=%0d beat=%0d ack=%b dvalid=%b want 1/0", s, j, b_ack[s], s_dvalid[s]);
                end
                mem_m[s][a] = wd[j];
                exp_q.push_back({12'(a), wd[j]});
                @(negedge clk);
                e = exp_q.pop_front();
                total++;
                if (b_ack[s] !== 1'b1 || s_dvalid[s] !== 1'b1 || {s_daddr[s], s_dout[s]} !== e) begin
                    bad++;
                    $display("FAIL commit s=%0d beat=%0d ack=%b dvalid=%b addr/data=%h want 1/1/%h",
                             s, j, b_ack[s], s_dvalid[s], {s_daddr[s], s_dout[s]}, e);
                end
                a = (a + 1) % depth[s];
            end
        end else if (!nak) begin
            for (int j = 0; j < beats; j++) begin
                got = '0;
                for (int k = 0; k < 8; k++) begin
                    @(negedge clk);
                    if (j == 0 && k == cut_bits && cut_rst) begin
                        rst = 1'b1;
                        @(negedge clk);
                        total++;
                        if ({b_bus_in[s], b_ack[s], b_sbsy[s], b_ready[s], s_dvalid[s], s_dout[s], s_daddr[s]} !== 25'd0) begin
                            bad++;
                            $display("FAIL rst_outputs s=%0d got=%h want 0", s,
                                     {b_bus_in[s], b_ack[s], b_sbsy[s], b_ready[s], s_dvalid[s], s_dout[s], s_daddr[s]});
                        end
                        rst       = 1'b0;
                        ad_sel[s] = 1'b0;
                        @(negedge clk);
                        total++;
                        if (b_ready[s] !== 1'b1) begin
                            bad++;
                            $display("FAIL rst_release s=%0d ready=%b want 1", s, b_ready[s]);
                        end
                        return;
                    end
                    got[k] = b_bus_in[s];
                end
                total++;
                if (got !== mem_m[s][a]) begin
                    bad++;
                    $display("FAIL read_word s=%0d addr=%0h got=%h want %h", s, a, got, mem_m[s][a]);
                end
                a = (a + 1) % depth[s];
            end
        end
        @(negedge clk);
        total++;
        if (b_ready[s] !== 1'b1 || b_sbsy[s] !== 1'b0) begin
            bad++;
            $display("FAIL idle_after s=%0d ready=%b sbsy=%b want 1/0", s, b_ready[s], b_sbsy[s]);
        end
        ad_sel[s]    = 1'b0;
        b_bus_out[s] = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            total++;
            if ({b_bus_in[s], b_ack[s], b_sbsy[s], b_ready[s], s_dvalid[s], s_dout[s], s_daddr[s]} !== 25'd0) begin
                bad++;
                $display("FAIL reset_outputs s=%0d got=%h want 0", s,
                         {b_bus_in[s], b_ack[s], b_sbsy[s], b_ready[s], s_dvalid[s], s_dout[s], s_daddr[s]});
            end
        end
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            total++;
            if (b_ready[s] !== 1'b1) begin
                bad++;
                $display("FAIL reset_ready s=%0d got=%b want 1", s, b_ready[s]);
            end
        end
    endtask

    task automatic test_single();
        int p;
        p = pulse_cnt[0];
        wd[0] = 8'h5A;
        xfer(0, 1'b1, 'h123, 1, -1, 1'b0);
        total++;
        if (pulse_cnt[0] - p !== 1) begin
            bad++;
            $display("FAIL single_pulses got=%0d want 1", pulse_cnt[0] - p);
        end
        xfer(0, 1'b0, 'h123, 1, -1, 1'b0);
    endtask

    task automatic test_burst_wrap();
        int p;
        p = pulse_cnt[0];
        wd = '{8'h11, 8'h22, 8'h33, 8'h44};
        xfer(0, 1'b1, 'hFFE, 4, -1, 1'b0);
        total++;
        if (pulse_cnt[0] - p !== 4) begin
            bad++;
            $display("FAIL burst_pulses got=%0d want 4", pulse_cnt[0] - p);
        end
        xfer(0, 1'b0, 'hFFE, 4, -1, 1'b0);
        xfer(0, 1'b0, 'h000, 2, -1, 1'b0);
    endtask

    task automatic test_abort();
        int p;
        p = pulse_cnt[0];
        wd[0] = 8'h3C;
        xfer(0, 1'b1, 'h010, 1, 4, 1'b0);
        total++;
        if (pulse_cnt[0] - p !== 0) begin
            bad++;
            $display("FAIL abort_pulses got=%0d want 0", pulse_cnt[0] - p);
        end
        xfer(0, 1'b0, 'h010, 1, -1, 1'b0);
    endtask

    task automatic test_nak_depth();
        int p;
        p = pulse_cnt[1];
        wd[0] = 8'h77;
        xfer(1, 1'b1, 'hC00, 1, -1, 1'b0);
        xfer(1, 1'b0, 'hC00, 1, -1, 1'b0);
        total++;
        if (pulse_cnt[1] - p !== 0) begin
            bad++;
            $display("FAIL nak_pulses got=%0d want 0", pulse_cnt[1] - p);
        end
        wd = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        xfer(1, 1'b1, 2998, 3, -1, 1'b0);
        xfer(1, 1'b0, 0, 1, -1, 1'b0);
        xfer(1, 1'b0, 2999, 2, -1, 1'b0);
    endtask

    task automatic test_rst_mid_read();
        xfer(0, 1'b0, 'hFFE, 3, 3, 1'b1);
        xfer(0, 1'b0, 'hFFE, 4, -1, 1'b0);
    endtask

    task automatic test_random();
        int s;
        int addr;
        for (int n = 0; n < 30; n++) begin
            s = int'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                addr = depth[s] - int'($urandom_range(1, 3));
            end else begin
                addr = int'($urandom_range(0, (s == 0) ? 4095 : 3199));
            end
            for (int j = 0; j < 4; j++) wd[j] = 8'($urandom);
            xfer(s, 1'($urandom_range(0, 1)), addr, int'($urandom_range(1, 4)), -1, 1'b0);
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            ad_sel[s]    = 1'b0;
            b_rw[s]      = 1'b0;
            b_bus_out[s] = 1'b0;
            for (int i = 0; i < 4096; i++) mem_m[s][i] = 8'hAD;
        end
        test_reset();
        test_single();
        test_burst_wrap();
        test_abort();
        test_nak_depth();
        test_rst_mid_read();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
